// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage types, constants and helpers
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HELD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] IF_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0000;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, hold and clear (clear wins)
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = IF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_instr,
  input  logic        d_misalign,
  output logic [31:0] q_pc,
  output logic [31:0] q_pc4,
  output logic [31:0] q_instr,
  output logic        q_valid,
  output logic        q_misalign
);

  logic [31:0] pc_d, pc_q, pc4_d, pc4_q, instr_d, instr_q;
  logic        valid_d, valid_q, misalign_d, misalign_q;

  // A bubble keeps the PC fields; only the payload is squashed.
  always_comb begin
    pc_d       = pc_q;
    pc4_d      = pc4_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;
    if (clear) begin
      instr_d    = NOP_INSTR;
      valid_d    = 1'b0;
      misalign_d = 1'b0;
    end else if (load) begin
      pc_d       = d_pc;
      pc4_d      = pc_plus4(d_pc);
      instr_d    = d_instr;
      valid_d    = 1'b1;
      misalign_d = d_misalign;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      pc4_q      <= pc_plus4(RESET_PC);
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc4_q      <= pc4_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign q_pc       = pc_q;
  assign q_pc4      = pc4_q;
  assign q_instr    = instr_q;
  assign q_valid    = valid_q;
  assign q_misalign = misalign_q;

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage: request FSM, skid buffer, wait timeout, IF/ID
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = IF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR,
  parameter int          WAIT_W    = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PC,
  input  logic        stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] nextPC,
  output logic        pc_hold,
  output logic [31:0] IfId_PC,
  output logic [31:0] IfId_PC4,
  output logic [31:0] IfId_Instr,
  output logic        IfId_valid,
  output logic        IfId_misalign,
  output logic        imem_timeout
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};

  fetch_state_e      state_d, state_q;
  logic [31:0]       skid_pc_d, skid_pc_q, skid_instr_d, skid_instr_q;
  logic              skid_mis_d, skid_mis_q, skid_valid_d, skid_valid_q;
  logic [WAIT_W-1:0] wait_cnt_d, wait_cnt_q;
  logic              timeout_d, timeout_q;

  logic        misalign, fetching, got;
  logic [31:0] got_instr;
  logic        ld, clr;
  logic [31:0] ld_pc, ld_instr;
  logic        ld_mis;

  assign misalign  = (PC[1:0] != 2'b00);
  assign fetching  = (state_q == FETCH) || (state_q == WAIT);
  // A misaligned PC never reaches memory; it completes at once as a NOP.
  assign got       = fetching && (misalign || imem_ready);
  assign got_instr = misalign ? NOP_INSTR : imem_rdata;
  assign imem_req  = fetching && !misalign;
  assign imem_addr = PC;
  assign nextPC    = pc_plus4(PC);

  always_comb begin
    state_d      = state_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    skid_mis_d   = skid_mis_q;
    skid_valid_d = skid_valid_q;
    wait_cnt_d   = '0;
    timeout_d    = timeout_q;
    pc_hold      = 1'b1;
    ld           = 1'b0;
    clr          = 1'b0;
    ld_pc        = PC;
    ld_instr     = got_instr;
    ld_mis       = misalign;

    if (flush) begin
      clr          = 1'b1;
      skid_valid_d = 1'b0;
      pc_hold      = 1'b0;
      if ((imem_req || state_q == DROP) && !imem_ready) state_d = DROP;
      else                                              state_d = FETCH;
    end else begin
      unique case (state_q)
        FETCH, WAIT: begin
          if (got && !stall) begin
            ld      = 1'b1;
            pc_hold = 1'b0;
            state_d = FETCH;
          end else if (got) begin
            skid_pc_d    = PC;
            skid_instr_d = got_instr;
            skid_mis_d   = misalign;
            skid_valid_d = 1'b1;
            state_d      = HELD;
          end else begin
            // The FETCH cycle counts as the first waited cycle.
            wait_cnt_d = (state_q == FETCH) ? WAIT_W'(1) :
                         (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + WAIT_W'(1);
            if (wait_cnt_d == WAIT_MAX) timeout_d = 1'b1;
            state_d = WAIT;
          end
        end
        HELD: begin
          if (!stall) begin
            ld           = skid_valid_q;
            ld_pc        = skid_pc_q;
            ld_instr     = skid_instr_q;
            ld_mis       = skid_mis_q;
            skid_valid_d = 1'b0;
            pc_hold      = 1'b0;
            state_d      = FETCH;
          end
        end
        DROP: begin
          if (imem_ready) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= FETCH;
      skid_pc_q    <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
      skid_mis_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_mis_q   <= skid_mis_d;
      skid_valid_q <= skid_valid_d;
      wait_cnt_q   <= wait_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign imem_timeout = timeout_q;

  if_id_reg #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (Clk),
    .reset      (Reset),
    .load       (ld),
    .clear      (clr),
    .d_pc       (ld_pc),
    .d_instr    (ld_instr),
    .d_misalign (ld_mis),
    .q_pc       (IfId_PC),
    .q_pc4      (IfId_PC4),
    .q_instr    (IfId_Instr),
    .q_valid    (IfId_valid),
    .q_misalign (IfId_misalign)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

  logic        Clk = 1'b0;
  logic        Reset, stall, flush, imem_ready;
  logic [31:0] PC, imem_rdata;
  logic        imem_req, pc_hold, IfId_valid, IfId_misalign, imem_timeout;
  logic [31:0] imem_addr, nextPC, IfId_PC, IfId_PC4, IfId_Instr;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 Clk = ~Clk;

  if_fetch_stage dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .PC            (PC),
    .stall         (stall),
    .flush         (flush),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .nextPC        (nextPC),
    .pc_hold       (pc_hold),
    .IfId_PC       (IfId_PC),
    .IfId_PC4      (IfId_PC4),
    .IfId_Instr    (IfId_Instr),
    .IfId_valid    (IfId_valid),
    .IfId_misalign (IfId_misalign),
    .imem_timeout  (imem_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic rdy, input logic [31:0] rd,
                       input logic stl, input logic fl);
    PC = pc; imem_ready = rdy; imem_rdata = rd; stall = stl; flush = fl;
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    drive(32'h0000_3000, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_valid", {31'b0, IfId_valid}, 32'd0);
    check("rst_instr", IfId_Instr, 32'h0);
    check("rst_pc", IfId_PC, 32'h0000_3000);
    check("rst_pc4", IfId_PC4, 32'h0000_3004);
    check("rst_mis", {31'b0, IfId_misalign}, 32'd0);
    check("rst_tmo", {31'b0, imem_timeout}, 32'd0);
    Reset = 1'b0;

    // zero-wait run
    for (int i = 0; i < 3; i++) begin
      drive(32'h0000_3000 + 32'(4 * i), 1'b1, 32'h1111_0000 + 32'(i), 1'b0, 1'b0);
      check("zw_hold", {31'b0, pc_hold}, 32'd0);
      check("zw_req", {31'b0, imem_req}, 32'd1);
      check("zw_addr", imem_addr, 32'h0000_3000 + 32'(4 * i));
      check("zw_next", nextPC, 32'h0000_3004 + 32'(4 * i));
      tick();
      check("zw_ifpc", IfId_PC, 32'h0000_3000 + 32'(4 * i));
      check("zw_instr", IfId_Instr, 32'h1111_0000 + 32'(i));
      check("zw_valid", {31'b0, IfId_valid}, 32'd1);
    end

    // three wait cycles at 3010
    for (int i = 0; i < 3; i++) begin
      drive(32'h0000_3010, 1'b0, 32'h0, 1'b0, 1'b0);
      check("wt_hold", {31'b0, pc_hold}, 32'd1);
      check("wt_req", {31'b0, imem_req}, 32'd1);
      tick();
      check("wt_keep", IfId_PC, 32'h0000_3008);
    end
    drive(32'h0000_3010, 1'b1, 32'h2222_3010, 1'b0, 1'b0);
    check("wt_rdy_hold", {31'b0, pc_hold}, 32'd0);
    tick();
    check("wt_ifpc", IfId_PC, 32'h0000_3010);
    check("wt_instr", IfId_Instr, 32'h2222_3010);

    // stall skid at 3020
    drive(32'h0000_3020, 1'b1, 32'h3333_3020, 1'b1, 1'b0);
    check("sk_hold1", {31'b0, pc_hold}, 32'd1);
    tick();
    check("sk_keep1", IfId_PC, 32'h0000_3010);
    drive(32'h0000_3020, 1'b0, 32'hBAD0_BAD0, 1'b1, 1'b0);
    check("sk_req2", {31'b0, imem_req}, 32'd0);
    check("sk_hold2", {31'b0, pc_hold}, 32'd1);
    tick();
    check("sk_keep2", IfId_Instr, 32'h2222_3010);
    drive(32'h0000_3020, 1'b0, 32'hBAD0_BAD0, 1'b0, 1'b0);
    check("sk_req3", {31'b0, imem_req}, 32'd0);
    check("sk_hold3", {31'b0, pc_hold}, 32'd0);
    tick();
    check("sk_ifpc", IfId_PC, 32'h0000_3020);
    check("sk_instr", IfId_Instr, 32'h3333_3020);
    check("sk_valid", {31'b0, IfId_valid}, 32'd1);

    // flush during WAIT, late response dropped
    drive(32'h0000_3030, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(32'h0000_3030, 1'b0, 32'h0, 1'b1, 1'b1);
    check("fl_hold", {31'b0, pc_hold}, 32'd0);
    tick();
    check("fl_valid", {31'b0, IfId_valid}, 32'd0);
    check("fl_instr", IfId_Instr, 32'h0);
    drive(32'h0000_3100, 1'b0, 32'h0, 1'b0, 1'b0);
    check("dr_req1", {31'b0, imem_req}, 32'd0);
    check("dr_hold1", {31'b0, pc_hold}, 32'd1);
    tick();
    drive(32'h0000_3100, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("dr_req2", {31'b0, imem_req}, 32'd0);
    check("dr_hold2", {31'b0, pc_hold}, 32'd1);
    tick();
    check("dr_drop", {31'b0, IfId_valid}, 32'd0);
    drive(32'h0000_3100, 1'b1, 32'h4444_3100, 1'b0, 1'b0);
    check("tg_req", {31'b0, imem_req}, 32'd1);
    check("tg_addr", imem_addr, 32'h0000_3100);
    tick();
    check("tg_ifpc", IfId_PC, 32'h0000_3100);
    check("tg_instr", IfId_Instr, 32'h4444_3100);

    // misaligned PC, then wrap
    drive(32'h0000_3002, 1'b0, 32'h5555_5555, 1'b0, 1'b0);
    check("ma_req", {31'b0, imem_req}, 32'd0);
    check("ma_hold", {31'b0, pc_hold}, 32'd0);
    tick();
    check("ma_mis", {31'b0, IfId_misalign}, 32'd1);
    check("ma_instr", IfId_Instr, 32'h0);
    check("ma_valid", {31'b0, IfId_valid}, 32'd1);
    check("ma_pc", IfId_PC, 32'h0000_3002);
    drive(32'hFFFF_FFFC, 1'b1, 32'h6666_6666, 1'b0, 1'b0);
    check("wr_next", nextPC, 32'h0000_0000);
    tick();
    check("wr_pc4", IfId_PC4, 32'h0000_0000);
    check("wr_mis", {31'b0, IfId_misalign}, 32'd0);

    // timeout after 15 waited cycles, then reset in WAIT
    drive(32'h0000_3200, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) tick();
    check("to_early", {31'b0, imem_timeout}, 32'd0);
    tick();
    check("to_set", {31'b0, imem_timeout}, 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    drive(32'h0000_3000, 1'b0, 32'h0, 1'b0, 1'b0);
    check("rw_valid", {31'b0, IfId_valid}, 32'd0);
    check("rw_pc", IfId_PC, 32'h0000_3000);
    check("rw_pc4", IfId_PC4, 32'h0000_3004);
    check("rw_instr", IfId_Instr, 32'h0);
    check("rw_tmo", {31'b0, imem_timeout}, 32'd0);
    check("rw_req", {31'b0, imem_req}, 32'd1);
    check("rw_hold", {31'b0, pc_hold}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
